// File: rtl/hash_sequencer_pkg.sv
// Shared constants, state encoding and length saturation for the hash sequencer.
package hash_pkg;

  localparam int unsigned MAX_BYTES = 8;
  localparam logic [31:0] IV = 32'h811C9DC5;
  localparam logic [31:0] K  = 32'h9E3779B9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ABSORB = 2'd1,
    FINAL  = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Byte counts above MAX_BYTES clamp to MAX_BYTES.
  function automatic logic [3:0] sat_len(input logic [3:0] len);
    return (len > 4'(MAX_BYTES)) ? 4'(MAX_BYTES) : len;
  endfunction

endpackage

// File: rtl/hash_sequencer_if.sv
// Message-in / hash-out handshake bundle for hash_sequencer.
interface hash_sequencer_if;

  logic        in_valid;
  logic        in_ready;
  logic [63:0] data;
  logic [3:0]  data_len;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] hash;
  logic        busy;

  modport slave (
    input  in_valid, data, data_len, out_ready,
    output in_ready, out_valid, hash, busy
  );

  modport master (
    output in_valid, data, data_len, out_ready,
    input  in_ready, out_valid, hash, busy
  );

endinterface

// File: rtl/hash_sequencer_round.sv
// One hash round: xor byte into state, rotate left by ROT, add K.
module hash_round
  import hash_pkg::*;
#(
  parameter int unsigned ROT = 5
) (
  input  logic [31:0] h_in,
  input  logic [7:0]  b_in,
  output logic [31:0] h_out
);

  logic [31:0] mixed;
  logic [31:0] rotated;

  assign mixed   = h_in ^ {24'h0, b_in};
  assign rotated = {mixed[31-ROT:0], mixed[31:32-ROT]};
  assign h_out   = rotated + K;

endmodule

// File: rtl/hash_sequencer.sv
// Sequences hash_round over up to 8 message bytes plus FINAL_ROUNDS length-keyed rounds.
module hash_sequencer
  import hash_pkg::*;
#(
  parameter int unsigned FINAL_ROUNDS = 2,
  parameter int unsigned ROT          = 5
) (
  input  logic             clk,
  input  logic             reset,
  hash_sequencer_if.slave  bus
);

  state_t      state_q;
  logic [63:0] msg_q;
  logic [3:0]  len_q;
  logic [31:0] h_q;
  logic [2:0]  idx_q;
  logic [2:0]  fr_q;
  logic        out_valid_q;

  logic [3:0]  in_len;
  logic [7:0]  round_b;
  logic [31:0] h_next;
  logic        last_byte;
  logic        last_round;

  assign in_len     = sat_len(bus.data_len);
  assign last_byte  = ({1'b0, idx_q} == (len_q - 4'd1));
  assign last_round = (fr_q == 3'(FINAL_ROUNDS - 1));

  // The same round instance serves message bytes and length-keyed finalization.
  assign round_b = (state_q == FINAL) ? {4'h0, len_q} : msg_q[{idx_q, 3'b000} +: 8];

  hash_round #(.ROT(ROT)) u_round (
    .h_in  (h_q),
    .b_in  (round_b),
    .h_out (h_next)
  );

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.hash      = h_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      msg_q       <= '0;
      len_q       <= '0;
      h_q         <= IV;
      idx_q       <= '0;
      fr_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            msg_q   <= bus.data;
            len_q   <= in_len;
            h_q     <= IV;
            idx_q   <= '0;
            fr_q    <= '0;
            state_q <= (in_len == 4'd0) ? FINAL : ABSORB;
          end
        end
        ABSORB: begin
          h_q <= h_next;
          // idx holds at the last byte rather than wrapping.
          if (last_byte) begin
            state_q <= FINAL;
          end else begin
            idx_q <= idx_q + 3'd1;
          end
        end
        FINAL: begin
          h_q  <= h_next;
          fr_q <= fr_q + 3'd1;
          if (last_round) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hash_sequencer.sv
// Scoreboard bench for hash_sequencer: reference hashes queued at send, compared at output.
module tb_hash_sequencer;

  localparam int unsigned FR  = 2;
  localparam int unsigned ROT = 5;

  logic clk;
  logic reset;

  hash_sequencer_if bus ();

  hash_sequencer #(.FINAL_ROUNDS(FR), .ROT(ROT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_total = 0;
  int          n_bad   = 0;
  int          n_viol  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_hash;

  always @(negedge clk) begin
    if (bus.in_ready && bus.busy) n_viol++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rnd(input logic [31:0] h, input logic [7:0] b);
    logic [31:0] x;
    x = h ^ {24'h0, b};
    return ((x << ROT) | (x >> (32 - ROT))) + 32'h9E3779B9;
  endfunction

  function automatic int sat(input logic [3:0] l);
    return (l > 4'd8) ? 8 : int'(l);
  endfunction

  function automatic logic [31:0] model(input logic [63:0] d, input logic [3:0] l);
    logic [31:0] h;
    int n;
    n = sat(l);
    h = 32'h811C9DC5;
    for (int i = 0; i < n; i++) h = rnd(h, d[8*i +: 8]);
    for (int r = 0; r < int'(FR); r++) h = rnd(h, {4'h0, 4'(n)});
    return h;
  endfunction

  // Send one message, check latency, stall for `hold` cycles, then take the hash.
  task automatic do_msg(input logic [63:0] d, input logic [3:0] l, input int hold, input bit poke);
    int n;
    logic [31:0] exp_h;
    exp_q.push_back(model(d, l));
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_idle", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.data     = d;
    bus.data_len = l;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.data     = {$urandom, $urandom};
    bus.data_len = 4'($urandom_range(0, 15));
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
      if (poke && n == 2) begin
        bus.in_valid = 1'b1;
        bus.data     = {$urandom, $urandom};
        bus.data_len = 4'd5;
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    check("latency", 64'(n), 64'(sat(l) + int'(FR)));
    for (int i = 0; i < hold; i++) begin
      check("stall_valid", 64'(bus.out_valid), 64'd1);
      check("stall_hash", 64'(bus.hash), 64'(exp_q[0]));
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    exp_h = exp_q.pop_front();
    check("hash", 64'(bus.hash), 64'(exp_h));
    last_hash = bus.hash;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("b2b_ready", 64'(bus.in_ready), 64'd1);
    check("valid_drop", 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    logic [63:0] d;
    int seen;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.data      = '0;
    bus.data_len  = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_hash", 64'(bus.hash), 64'h811C9DC5);

    // Empty message with a 3-cycle output stall.
    do_msg(64'h0, 4'd0, 3, 1'b0);
    check("empty_golden", 64'(last_hash), 64'hD79DC6F1);

    // Full message, then the saturating length gives the same result.
    do_msg(64'h0123456789ABCDEF, 4'd8, 0, 1'b0);
    do_msg(64'h0123456789ABCDEF, 4'd15, 1, 1'b0);
    check("sat_len_hash", 64'(last_hash), 64'(model(64'h0123456789ABCDEF, 4'd8)));

    // Bytes beyond the length must not matter.
    for (int t = 0; t < 20; t++) begin
      d = {$urandom, $urandom};
      d[23:0] = 24'hA1B2C3;
      do_msg(d, 4'd3, 0, 1'b0);
      check("unused_bytes", 64'(last_hash), 64'(model(64'h0000_0000_00A1_B2C3, 4'd3)));
    end

    // Reset at cycle 3 of a len-8 message discards it.
    bus.in_valid = 1'b1;
    bus.data     = 64'hFEDCBA9876543210;
    bus.data_len = 4'd8;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_ready", 64'(bus.in_ready), 64'd1);
    check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_hash", 64'(bus.hash), 64'h811C9DC5);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("no_out_after_rst", 64'(seen), 64'd0);
    do_msg(64'h00000000000000A5, 4'd1, 0, 1'b0);

    // in_valid pulsed mid-ABSORB is ignored.
    do_msg(64'h1122334455667788, 4'd8, 0, 1'b1);

    // Random back-to-back stream with random consumer stalls.
    for (int t = 0; t < 200; t++) begin
      do_msg({$urandom, $urandom}, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)));
    end
    check("ready_while_busy", 64'(n_viol), 64'd0);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
